// File: rtl/btn_latch_pkg.sv
// rtl/btn_latch_pkg.sv - shared mode encoding and counter sizing for btn_latch_bank
package btn_latch_pkg;

  typedef enum logic [1:0] {
    MODE_TRANSPARENT = 2'b00,
    MODE_CAPTURE     = 2'b01,
    MODE_TOGGLE      = 2'b10,
    MODE_SETCLR      = 2'b11
  } mode_e;

  // Width of a counter that must hold 0..cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int DEBOUNCE_CYCLES_DFLT = 270000;
  localparam int DEBOUNCE_CNT_W_DFLT  = cnt_width(DEBOUNCE_CYCLES_DFLT);

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - polarity normalise, 2-flop sync, debounce and press detect for one button
module btn_debounce
  import btn_latch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic state_o,
  output logic press_o
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             state_q, state_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised value agrees with the accepted state restarts the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i ^ ACTIVE_LOW;
      sync2_q <= sync1_q;
      state_q <= state_d;
      prev_q  <= state_q;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign press_o = state_q & ~prev_q;

endmodule

// File: rtl/btn_latch_bank.sv
// rtl/btn_latch_bank.sv - debounced button bank driving LEDs by mode; BTN_LATCH_BLINK_EN adds SETCLR blink
module btn_latch_bank
  import btn_latch_pkg::*;
#(
  parameter int CHANNELS          = 4,
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int ACTIVE_LOW        = 1,
  parameter int BLINK_HALF_PERIOD = 6750000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_gate,
  input  logic [CHANNELS-1:0] btn_data,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] press
);

  logic                gate_state, gate_press;
  logic [CHANNELS-1:0] data_state, data_press;
  mode_e               mode_q;
  logic [CHANNELS-1:0] led_q, led_d;
  logic [CHANNELS-1:0] press_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW != 0)
  ) u_gate (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_gate),
    .state_o(gate_state),
    .press_o(gate_press)
  );

  for (genvar g = 0; g < CHANNELS; g++) begin : g_data
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW != 0)
    ) u_data (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_data[g]),
      .state_o(data_state[g]),
      .press_o(data_press[g])
    );
  end

  always_comb begin
    led_d = led_q;
    unique case (mode_q)
      MODE_TRANSPARENT: if (gate_state) led_d = data_state;
      MODE_CAPTURE:     if (gate_press) led_d = data_state;
      MODE_TOGGLE:      led_d = led_q ^ data_press;
      // A simultaneous gate press clears everything except the channels pressed this cycle.
      MODE_SETCLR:      led_d = gate_press ? data_press : (led_q | data_press);
      default:          led_d = led_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_TRANSPARENT;
      led_q   <= '0;
      press_q <= '0;
    end else begin
      mode_q  <= mode_e'(mode);
      led_q   <= led_d;
      press_q <= data_press;
    end
  end

  assign press = press_q;

`ifdef BTN_LATCH_BLINK_EN
  localparam int               BLINK_W    = cnt_width(BLINK_HALF_PERIOD);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_PERIOD - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Blinking masks only the pins; led_q keeps the latched state.
  assign led = (mode_q == MODE_SETCLR) ? (led_q & {CHANNELS{blink_q}}) : led_q;
`else
  logic [31:0] unused_blink_half;
  assign unused_blink_half = 32'(BLINK_HALF_PERIOD);
  assign led               = led_q;
`endif

endmodule
